fpu_wb_ctrl: RTL

Result-side companion to `fpu_top`. It records the destination register of every issued FPU operation in order and accepts results from the FPU output handshake (`o_result`/`o_fflags`/`o_out_valid`/`i_out_ready`). It presents the results in order on a register-file writeback port. It also owns the floating-point CSRs: it accumulates retired exception flags into `fflags` and drives the dynamic rounding mode (`frm`) back into the FPU's `i_rm_fcsr`.

---
 rtl/fpu_wb_ctrl_if.sv | 45 ++++
 rtl/fpu_wb_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fpu_wb_ctrl_if.sv
// rtl/fpu_wb_ctrl_if.sv - issue, result and writeback handshakes between the FPU pipeline and fpu_wb_ctrl
//
// Signal names are taken from the controller's point of view (i_* into it, o_* out of it).
//   issue     : i_iss_fire, i_iss_rd, o_iss_allow
//   result    : i_res_valid, o_res_ready, i_res_data, i_res_fflags
//   writeback : o_wb_valid, i_wb_ready, o_wb_rd, o_wb_data
// slave  modport: the controller side.
// master modport: the pipeline / register-file side.

interface fpu_wb_ctrl_if #(
    parameter int FLEN  = 32,
    parameter int TAG_W = 5
);
    logic             i_iss_fire;
    logic [TAG_W-1:0] i_iss_rd;
    logic             o_iss_allow;

    logic             i_res_valid;
    logic             o_res_ready;
    logic [FLEN-1:0]  i_res_data;
    logic [4:0]       i_res_fflags;

    logic             o_wb_valid;
    logic             i_wb_ready;
    logic [TAG_W-1:0] o_wb_rd;
    logic [FLEN-1:0]  o_wb_data;

    modport slave (
        input  i_iss_fire, i_iss_rd,
        output o_iss_allow,
        input  i_res_valid, i_res_data, i_res_fflags,
        output o_res_ready,
        output o_wb_valid, o_wb_rd, o_wb_data,
        input  i_wb_ready
    );

    modport master (
        output i_iss_fire, i_iss_rd,
        input  o_iss_allow,
        output i_res_valid, i_res_data, i_res_fflags,
        input  o_res_ready,
        input  o_wb_valid, o_wb_rd, o_wb_data,
        output i_wb_ready
    );
endinterface

// File: rtl/fpu_wb_ctrl.sv
// rtl/fpu_wb_ctrl.sv - in-order FPU result writeback buffer and floating-point CSR owner
//
// Records the destination register of every issued FPU op, collects results in
// issue order, retires them in order to the register file, accumulates retired
// exception flags into fflags and supplies the dynamic rounding mode.
//   i_clk, i_rst     : clock, asynchronous active-high reset
//   bus (slave)      : issue / result / writeback handshakes
//   i_csr_we/addr/wdata, o_csr_rdata : CSR access (0x001 fflags, 0x002 frm, 0x003 fcsr)
//   o_frm, o_frm_invalid             : rounding mode to the FPU, reserved-value flag

module fpu_wb_ctrl #(
    parameter int FLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                i_clk,
    input  logic                i_rst,
    fpu_wb_ctrl_if.slave        bus,
    input  logic                i_csr_we,
    input  logic [11:0]         i_csr_addr,
    input  logic [31:0]         i_csr_wdata,
    output logic [31:0]         o_csr_rdata,
    output logic [2:0]          o_frm,
    output logic                o_frm_invalid
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [11:0] ADDR_FFLAGS = 12'h001;
    localparam logic [11:0] ADDR_FRM    = 12'h002;
    localparam logic [11:0] ADDR_FCSR   = 12'h003;

    logic [TAG_W-1:0] rd_q   [DEPTH];
    logic [FLEN-1:0]  data_q [DEPTH];
    logic [4:0]       flg_q  [DEPTH];

    logic [PTR_W-1:0] tag_ptr_q, tag_ptr_d;
    logic [PTR_W-1:0] res_ptr_q, res_ptr_d;
    logic [PTR_W-1:0] head_ptr_q, head_ptr_d;
    logic [CNT_W-1:0] tag_cnt_q, tag_cnt_d;
    logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
    logic [4:0]       fflags_q, fflags_d;
    logic [2:0]       frm_q, frm_d;

    logic iss_push, res_push, wb_pop;
    logic unused_wdata;

    // Handshake outputs depend on registered counters only, so a full buffer
    // does not admit a new issue in the same cycle a writeback frees a slot.
    assign bus.o_iss_allow = (tag_cnt_q < CNT_W'(DEPTH));
    assign bus.o_res_ready = (res_cnt_q < tag_cnt_q);
    assign bus.o_wb_valid  = (res_cnt_q != '0);
    assign bus.o_wb_rd     = rd_q[head_ptr_q];
    assign bus.o_wb_data   = data_q[head_ptr_q];

    // An issue fired while full is dropped rather than overwriting a live entry.
    assign iss_push = bus.i_iss_fire & bus.o_iss_allow;
    assign res_push = bus.i_res_valid & bus.o_res_ready;
    assign wb_pop   = bus.o_wb_valid & bus.i_wb_ready;

    assign o_frm         = frm_q;
    assign o_frm_invalid = (frm_q >= 3'd5);
    assign unused_wdata  = ^i_csr_wdata[31:8];

    always_comb begin
        tag_ptr_d  = iss_push ? tag_ptr_q + PTR_W'(1) : tag_ptr_q;
        res_ptr_d  = res_push ? res_ptr_q + PTR_W'(1) : res_ptr_q;
        head_ptr_d = wb_pop   ? head_ptr_q + PTR_W'(1) : head_ptr_q;
        tag_cnt_d  = tag_cnt_q + CNT_W'(iss_push) - CNT_W'(wb_pop);
        res_cnt_d  = res_cnt_q + CNT_W'(res_push) - CNT_W'(wb_pop);
    end

    // The retiring op is older than any same-cycle CSR write, so its flags
    // are ORed on top of the written value instead of being lost.
    always_comb begin
        fflags_d = fflags_q;
        frm_d    = frm_q;
        if (i_csr_we) begin
            case (i_csr_addr)
                ADDR_FFLAGS: fflags_d = i_csr_wdata[4:0];
                ADDR_FRM:    frm_d    = i_csr_wdata[2:0];
                ADDR_FCSR: begin
                    fflags_d = i_csr_wdata[4:0];
                    frm_d    = i_csr_wdata[7:5];
                end
                default: ;
            endcase
        end
        if (wb_pop) begin
            fflags_d = fflags_d | flg_q[head_ptr_q];
        end
    end

    always_comb begin
        o_csr_rdata = '0;
        case (i_csr_addr)
            ADDR_FFLAGS: o_csr_rdata = {27'd0, fflags_q};
            ADDR_FRM:    o_csr_rdata = {29'd0, frm_q};
            ADDR_FCSR:   o_csr_rdata = {24'd0, frm_q, fflags_q};
            default:     o_csr_rdata = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tag_ptr_q  <= '0;
            res_ptr_q  <= '0;
            head_ptr_q <= '0;
            tag_cnt_q  <= '0;
            res_cnt_q  <= '0;
            fflags_q   <= '0;
            frm_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
                flg_q[i]  <= '0;
            end
        end else begin
            tag_ptr_q  <= tag_ptr_d;
            res_ptr_q  <= res_ptr_d;
            head_ptr_q <= head_ptr_d;
            tag_cnt_q  <= tag_cnt_d;
            res_cnt_q  <= res_cnt_d;
            fflags_q   <= fflags_d;
            frm_q      <= frm_d;
            if (iss_push) begin
                rd_q[tag_ptr_q] <= bus.i_iss_rd;
            end
            if (res_push) begin
                data_q[res_ptr_q] <= bus.i_res_data;
                flg_q[res_ptr_q]  <= bus.i_res_fflags;
            end
        end
    end
endmodule
